// File: rtl/customized_sequence_scheduler.sv
// Playlist controller for customized_sequence_module: plays descriptor
// slots back-to-back and parks the generator on a constant-0 pattern.
module customized_sequence_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int DATA_W    = 256,
  parameter int SLOT_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [SLOT_W-1:0] cfg_addr,
  input  logic [7:0]        cfg_length,
  input  logic [7:0]        cfg_cycle,
  input  logic [7:0]        cfg_repeat,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [SLOT_W-1:0] last_slot,
  input  logic              loop_en,
  input  logic              start,
  input  logic              stop,
  output logic [7:0]        gen_length,
  output logic [7:0]        gen_cycle,
  output logic [DATA_W-1:0] gen_data,
  output logic              gen_refresh,
  output logic              busy,
  output logic [SLOT_W-1:0] cur_slot,
  output logic              slot_done,
  output logic              list_done,
  output logic              err
);

  localparam int AW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [SLOT_W:0] NS = (SLOT_W+1)'(NUM_SLOTS);
  localparam logic [SLOT_W-1:0] LAST_MAX = SLOT_W'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, PARK} state_t;

  state_t state, state_d;

  logic [7:0]        len_t [NUM_SLOTS];
  logic [7:0]        cyc_t [NUM_SLOTS];
  logic [7:0]        rep_t [NUM_SLOTS];
  logic [DATA_W-1:0] dat_t [NUM_SLOTS];

  logic [7:0]        len_q, cyc_q, rep_q;
  logic [DATA_W-1:0] dat_q;
  logic [7:0]        cyc_cnt, bit_cnt, rep_cnt;
  logic [SLOT_W-1:0] slot_q, last_c, nxt_slot, rd_slot;
  logic [AW-1:0]     rd_idx, wr_idx;
  logic [7:0]        t_len, t_cyc, t_rep;
  logic [DATA_W-1:0] t_dat;
  logic              t_valid, wr_ok, wrap_ok, last_pass;
  logic              load, park, go, err_set;

  assign wr_ok  = cfg_we && ({1'b0, cfg_addr} < NS);
  assign wr_idx = cfg_addr[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        len_t[i] <= '0;
        cyc_t[i] <= '0;
        rep_t[i] <= '0;
        dat_t[i] <= '0;
      end
    end else if (wr_ok) begin
      len_t[wr_idx] <= cfg_length;
      cyc_t[wr_idx] <= cfg_cycle;
      rep_t[wr_idx] <= cfg_repeat;
      dat_t[wr_idx] <= cfg_data;
    end
  end

  assign last_c   = ({1'b0, last_slot} >= NS) ? LAST_MAX : last_slot;
  assign nxt_slot = (slot_q < last_c) ? slot_q + SLOT_W'(1) : '0;
  assign wrap_ok  = (slot_q < last_c) || loop_en;

  // In RUN the table is read at the next slot so the refresh of the
  // following descriptor can be issued in the final clock of this one.
  assign rd_slot = (state == RUN) ? nxt_slot : slot_q;
  assign rd_idx  = rd_slot[AW-1:0];
  assign t_len   = len_t[rd_idx];
  assign t_cyc   = cyc_t[rd_idx];
  assign t_rep   = rep_t[rd_idx];
  assign t_dat   = dat_t[rd_idx];
  assign t_valid = (t_len != 8'd0) && (t_cyc != 8'd0);

  assign last_pass = (rep_q != 8'd0)
                  && (cyc_cnt == cyc_q - 8'd1)
                  && (bit_cnt == len_q - 8'd1)
                  && (rep_cnt == rep_q - 8'd1);

  always_comb begin
    state_d   = state;
    load      = 1'b0;
    park      = 1'b0;
    go        = 1'b0;
    err_set   = 1'b0;
    slot_done = 1'b0;
    list_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          go      = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (stop) begin
          state_d = PARK;
        end else if (!t_valid) begin
          err_set = 1'b1;
          state_d = PARK;
        end else begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = PARK;
        end else if (last_pass) begin
          slot_done = 1'b1;
          if (!wrap_ok) begin
            list_done = 1'b1;
            state_d   = PARK;
          end else if (!t_valid) begin
            err_set = 1'b1;
            state_d = PARK;
          end else begin
            load = 1'b1;
          end
        end
      end
      PARK: begin
        park    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign gen_refresh = load | park;
  assign gen_length  = park ? 8'd1 : (load ? t_len : len_q);
  assign gen_cycle   = park ? 8'd1 : (load ? t_cyc : cyc_q);
  assign gen_data    = park ? '0 : (load ? t_dat : dat_q);
  assign busy        = (state == LOAD) || (state == RUN);
  assign cur_slot    = slot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      len_q   <= 8'd1;
      cyc_q   <= 8'd1;
      rep_q   <= 8'd0;
      dat_q   <= '0;
      cyc_cnt <= 8'd0;
      bit_cnt <= 8'd0;
      rep_cnt <= 8'd0;
      slot_q  <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_d;
      if (go) begin
        slot_q <= '0;
        err    <= 1'b0;
      end
      if (err_set) err <= 1'b1;
      if (load) begin
        len_q   <= t_len;
        cyc_q   <= t_cyc;
        rep_q   <= t_rep;
        dat_q   <= t_dat;
        slot_q  <= rd_slot;
        cyc_cnt <= 8'd0;
        bit_cnt <= 8'd0;
        rep_cnt <= 8'd0;
      end else if (park) begin
        len_q <= 8'd1;
        cyc_q <= 8'd1;
        rep_q <= 8'd0;
        dat_q <= '0;
      end else if (state == RUN) begin
        if (cyc_cnt == cyc_q - 8'd1) begin
          cyc_cnt <= 8'd0;
          if (bit_cnt == len_q - 8'd1) begin
            bit_cnt <= 8'd0;
            rep_cnt <= rep_cnt + 8'd1;
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end else begin
          cyc_cnt <= cyc_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: doc/customized_sequence_scheduler.md
Name: customized_sequence_scheduler

Overview:
- Playlist controller for customized_sequence_module. Holds NUM_SLOTS pattern descriptors (length, cycle, data, repeat) and drives the generator's length/cycle/data/refresh inputs.
- Plays each slot for repeat full passes, then reloads the next slot with no gap on seq.
- Optionally loops the playlist. On stop or end, parks the generator on a constant-0 pattern.
- Sits between the CPU/config register block and the generator.

Parameters:
- NUM_SLOTS, 4: number of descriptor slots (2..16).
- DATA_W, 256: pattern width; must match the generator's data port.
- SLOT_W, 4: slot index width; NUM_SLOTS <= 2**SLOT_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  write strobe for one descriptor slot
- cfg_addr  in  SLOT_W  slot index written; index >= NUM_SLOTS is ignored
- cfg_length  in  8  bits per pass
- cfg_cycle  in  8  clocks per bit
- cfg_repeat  in  8  passes per slot; 0 = repeat until stop
- cfg_data  in  DATA_W  pattern, bit 0 first
- last_slot  in  SLOT_W  index of the final playlist slot
- loop_en  in  1  after last_slot, wrap to slot 0
- start  in  1  pulse: begin at slot 0
- stop  in  1  pulse: abort playback
- gen_length  out  8  to generator length
- gen_cycle  out  8  to generator cycle
- gen_data  out  DATA_W  to generator data
- gen_refresh  out  1  to generator refresh
- busy  out  1  playback active
- cur_slot  out  SLOT_W  slot currently loaded
- slot_done  out  1  1-clock pulse when a slot's last pass completes
- list_done  out  1  1-clock pulse when playback ends without loop
- err  out  1  sticky; cleared by start

Behaviour:
- Reset values (async, rst_n low):
  - gen_length=1, gen_cycle=1, gen_data=0, gen_refresh=0.
  - busy=0, cur_slot=0, slot_done=0, list_done=0, err=0.
  - All descriptor slots cleared to zero.
- A slot is valid iff length != 0 and cycle != 0. A last_slot >= NUM_SLOTS is treated as NUM_SLOTS-1.
- States: IDLE, LOAD, RUN, PARK.
- IDLE:
  - On start (and not stop): clear err, set slot index to 0, go to LOAD.
  - start while busy is ignored.
- LOAD (1 clock):
  - If the slot is invalid: set err and go to PARK.
  - Otherwise: latch the slot's length/cycle/data/repeat into the gen_* outputs and working registers, assert gen_refresh for this clock, set cur_slot, clear counters, go to RUN.
- RUN: internal cyc_cnt, bit_cnt and rep_cnt mirror the generator exactly.
  - If refresh is sampled at edge E0, bit k appears on seq after edge E0+k*C.
  - A pass completes at edge E0+L*C.
- Slot completion:
  - After R passes (R = repeat != 0), gen_refresh for the next slot is asserted in the clock preceding edge E0+R*L*C. The next slot's data[0] therefore follows the previous slot's last bit back-to-back.
  - This final-clock evaluation is done combinationally in RUN, so no extra LOAD clock is inserted between slots. A LOAD-equivalent refresh is issued from RUN.
  - slot_done pulses in that same clock.
- Next-slot selection at slot completion:
  - If slot < last_slot: next = slot+1.
  - Else if loop_en: next = 0.
  - Else: pulse list_done and go to PARK.
  - An invalid next slot sets err and goes to PARK, with no refresh of the invalid descriptor.
- repeat=0: the slot plays indefinitely; only stop leaves RUN.
- PARK (1 clock):
  - Drive gen_length=1, gen_cycle=1, gen_data=0 and assert gen_refresh, so seq goes 0 on the next edge.
  - Go to IDLE with busy=0.
- busy is 1 in LOAD and RUN, 0 in IDLE and PARK.
- stop in LOAD or RUN: go to PARK next clock; any pending refresh or slot_done in that clock is suppressed. stop in IDLE is ignored. stop and start in the same clock: stop wins.
- Config writes:
  - Accepted in any state.
  - A write to a slot takes effect at that slot's next load; gen_* stay latched for the playing slot.
  - A write and a load of the same slot in the same clock: the load uses the old contents.
- Counter widths:
  - cyc_cnt and bit_cnt are 8-bit, compared against C-1 and L-1.
  - rep_cnt is 8-bit, compared against R-1.
  - No wrap beyond 255 passes is needed.

Test Plan:
- Slot0 {L=4, C=2, R=2, data=0b1011}, last_slot=0, loop_en=0, start → one refresh; seq = 1,1,1,1,0,0,1,1 twice (16 clocks); slot_done and list_done at clock 16; PARK refresh; seq then 0, busy=0.
- Slot0 {L=3, C=1, R=1, data=0b110}, slot1 {L=2, C=3, R=1, data=0b01}, last_slot=1 → seq = 0,1,1 then 1,1,1,0,0,0 with no gap; refreshes exactly 3 clocks apart.
- Same two slots with loop_en=1 run for 30 clocks; then stop mid-bit → slot order 0,1,0,1…; PARK one clock after stop; seq=0 afterward; list_done never pulses.
- Slot1 with cycle=0, last_slot=1 → slot0 plays fully; err=1; slot1 is never refreshed; PARK. A subsequent start clears err.
- Rewrite slot0 data mid-play with loop_en=1 → current pass unchanged; new data appears at the next slot0 load.
- rst_n asserted mid-RUN → all outputs return to reset values immediately; start after release plays from slot 0 with an empty (invalid) table → err.
